chunk_serializer: RTL

- Downstream neighbour of the 512-bit chunk assembly stage. It takes each assembled 512-bit chunk, marked by a single-cycle valid pulse, and re-emits it as 16 consecutive 32-bit words on an AXI4-Stream master port toward the DMA/output path.
- A two-entry ping-pong buffer lets the next chunk be captured while the current one drains under back-pressure.
- It flags overflow if the upstream stage pulses while both buffer entries are occupied.

---
 rtl/chunk_serializer_if.sv | 26 ++
 rtl/chunk_serializer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/chunk_serializer_if.sv
// Handshake and data bundle for chunk_serializer: the chunk-capture side
// (512-bit chunk + valid pulse + ready) and the AXI4-Stream word output.
interface chunk_serializer_if #(
   parameter int WORD_W = 32,
   parameter int WORDS  = 16
);
   logic [WORD_W*WORDS-1:0] chunk_ser_data_in;
   logic                    chunk_ser_valid;
   logic                    chunk_ser_ready;
   logic [WORD_W-1:0]       m_axis_tdata;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic                    m_axis_tlast;

   // Serializer view
   modport master (
      input  chunk_ser_data_in, chunk_ser_valid, m_axis_tready,
      output chunk_ser_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   // Environment view (chunk producer and stream consumer)
   modport slave (
      output chunk_ser_data_in, chunk_ser_valid, m_axis_tready,
      input  chunk_ser_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/chunk_serializer.sv
// chunk_serializer: captures 512-bit chunks into a two-entry ping-pong buffer
// and replays each as 16 consecutive 32-bit AXI4-Stream words, word 0 being
// the most significant slice. Pulses arriving with both entries busy are
// dropped and latch a sticky overflow flag.
module chunk_serializer #(
   parameter int WORD_W = 32,
   parameter int WORDS  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                chunk_ser_clk,
   input  logic                chunk_ser_resetn,
   chunk_serializer_if.master  bus,
   output logic                chunk_ser_overflow,
   output logic [CNT_W-1:0]    chunk_ser_count
);
   localparam int CHUNK_W = WORD_W * WORDS;
   localparam int PTR_W   = $clog2(WORDS);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t                state;
   occ_t                state_next;
   logic [CHUNK_W-1:0]  buf0;
   logic [CHUNK_W-1:0]  buf1;
   logic                wr_ptr;
   logic                rd_ptr;
   logic [PTR_W-1:0]    word_ptr;

   logic                out_valid;
   logic                last_word;
   logic                xfer;
   logic                last_xfer;
   logic                ready;
   logic                accept;
   logic                drop;
   logic [CHUNK_W-1:0]  rd_entry;
   logic [WORD_W-1:0]   words [WORDS];

   // Handshake decode: a pulse fits if a slot is free or the draining entry frees one this cycle
   always_comb begin
      out_valid = (state != EMPTY);
      last_word = (word_ptr == PTR_W'(WORDS - 1));
      xfer      = out_valid & bus.m_axis_tready;
      last_xfer = xfer & last_word;
      ready     = (state != FULL) | last_xfer;
      accept    = bus.chunk_ser_valid & ready;
      drop      = bus.chunk_ser_valid & ~ready;
   end

   // Occupancy next-state: accept adds an entry, a finished chunk removes one
   always_comb begin
      state_next = state;
      case (state)
         EMPTY: begin
            if (accept) state_next = ONE;
            else        state_next = EMPTY;
         end
         ONE: begin
            if (accept && !last_xfer)      state_next = FULL;
            else if (!accept && last_xfer) state_next = EMPTY;
            else                           state_next = ONE;
         end
         FULL: begin
            if (last_xfer && !accept) state_next = ONE;
            else                      state_next = FULL;
         end
         default: state_next = EMPTY;
      endcase
   end

   // Slice the draining entry into words, word 0 taken from the top bits
   always_comb begin
      rd_entry = rd_ptr ? buf1 : buf0;
      for (int i = 0; i < WORDS; i++) begin
         words[i] = rd_entry[(WORDS-1-i)*WORD_W +: WORD_W];
      end
   end

   assign bus.chunk_ser_ready = ready;
   assign bus.m_axis_tvalid   = out_valid;
   assign bus.m_axis_tlast    = out_valid & last_word;
   assign bus.m_axis_tdata    = out_valid ? words[word_ptr] : {WORD_W{1'b0}};

   // Occupancy state register
   always_ff @(posedge chunk_ser_clk or negedge chunk_ser_resetn) begin
      if (!chunk_ser_resetn) state <= EMPTY;
      else                   state <= state_next;
   end

   // Chunk capture into the entry at the write pointer; the other entry is untouched
   always_ff @(posedge chunk_ser_clk or negedge chunk_ser_resetn) begin
      if (!chunk_ser_resetn) begin
         buf0   <= {CHUNK_W{1'b0}};
         buf1   <= {CHUNK_W{1'b0}};
         wr_ptr <= 1'b0;
      end else if (accept) begin
         if (wr_ptr) buf1 <= bus.chunk_ser_data_in;
         else        buf0 <= bus.chunk_ser_data_in;
         wr_ptr <= ~wr_ptr;
      end else begin
         wr_ptr <= wr_ptr;
      end
   end

   // Word stepping, entry switch and completed-chunk counting on each transfer
   always_ff @(posedge chunk_ser_clk or negedge chunk_ser_resetn) begin
      if (!chunk_ser_resetn) begin
         word_ptr        <= {PTR_W{1'b0}};
         rd_ptr          <= 1'b0;
         chunk_ser_count <= {CNT_W{1'b0}};
      end else if (last_xfer) begin
         word_ptr        <= {PTR_W{1'b0}};
         rd_ptr          <= ~rd_ptr;
         chunk_ser_count <= chunk_ser_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (xfer) begin
         word_ptr        <= word_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         word_ptr        <= word_ptr;
      end
   end

   // Sticky overflow: set by any dropped pulse, cleared only by reset
   always_ff @(posedge chunk_ser_clk or negedge chunk_ser_resetn) begin
      if (!chunk_ser_resetn) chunk_ser_overflow <= 1'b0;
      else if (drop)         chunk_ser_overflow <= 1'b1;
      else                   chunk_ser_overflow <= chunk_ser_overflow;
   end
endmodule
